// File: rtl/avalon_bus_ram.sv
// Avalon-MM slave memory with an instruction region and a data region, programmable
// wait states, byte-lane writes and a sticky bus error flag.
module avalon_bus_ram #(
  parameter logic [31:0] DATA_BASE       = 32'h0000_0000,
  parameter int          DATA_WORDS      = 1024,
  parameter logic [31:0] INSTR_BASE      = 32'hBFC0_0000,
  parameter int          INSTR_WORDS     = 1024,
  parameter int          WAIT_CYCLES     = 1,
  parameter string       INSTR_INIT_FILE = "",
  parameter string       DATA_INIT_FILE  = ""
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] address,
  input  logic        read,
  input  logic        write,
  input  logic [3:0]  byteenable,
  input  logic [31:0] writedata,
  output logic        waitrequest,
  output logic [31:0] readdata,
  output logic        bus_error
);

  localparam int          IAW     = (INSTR_WORDS > 1) ? $clog2(INSTR_WORDS) : 1;
  localparam int          DAW     = (DATA_WORDS > 1) ? $clog2(DATA_WORDS) : 1;
  localparam logic [32:0] L_I_END = {1'b0, INSTR_BASE} + 33'(4 * INSTR_WORDS);
  localparam logic [32:0] L_D_END = {1'b0, DATA_BASE} + 33'(4 * DATA_WORDS);
  localparam logic [3:0]  L_WAIT  = 4'(WAIT_CYCLES);

  logic [31:0] r_imem [INSTR_WORDS];
  logic [31:0] r_dmem [DATA_WORDS];
  logic [3:0]  r_cnt;
  logic [31:0] r_readdata;
  logic        r_bus_error;

  logic           w_req;
  logic           w_done;
  logic           w_ihit;
  logic           w_dhit;
  logic [IAW-1:0] w_iidx;
  logic [DAW-1:0] w_didx;
  logic [31:0]    w_word;
  logic           w_err;
  logic [31:0]    w_rd_word;
  logic           w_wr_en;

  assign w_req  = read | write;
  assign w_done = w_req && (r_cnt == L_WAIT);

  assign w_ihit = ({1'b0, address} >= {1'b0, INSTR_BASE}) && ({1'b0, address} < L_I_END);
  assign w_dhit = ({1'b0, address} >= {1'b0, DATA_BASE}) && ({1'b0, address} < L_D_END);
  assign w_iidx = IAW'((address - INSTR_BASE) >> 2);
  assign w_didx = DAW'((address - DATA_BASE) >> 2);
  assign w_word = w_ihit ? r_imem[w_iidx] : r_dmem[w_didx];

  // Unmapped, misaligned and read+write accesses all complete but have no memory effect.
  assign w_err     = !(w_ihit || w_dhit) || (address[1:0] != 2'b00) || (read && write);
  assign w_rd_word = w_err ? 32'h0000_0000 : w_word;
  assign w_wr_en   = !reset && w_done && write && !w_err;

  assign waitrequest = w_req && (r_cnt != L_WAIT);
  assign readdata    = (w_done && read) ? w_rd_word : r_readdata;
  assign bus_error   = r_bus_error;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt       <= 4'd0;
      r_readdata  <= 32'h0000_0000;
      r_bus_error <= 1'b0;
    end else if (w_req) begin
      if (w_done) begin
        r_cnt <= 4'd0;
        if (read) r_readdata <= w_rd_word;
        if (w_err) r_bus_error <= 1'b1;
      end else begin
        r_cnt <= r_cnt + 4'd1;
      end
    end else if (r_cnt != 4'd0) begin
      // Master withdrew its request mid-stall.
      r_cnt       <= 4'd0;
      r_bus_error <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (w_wr_en && byteenable[i]) begin
        if (w_ihit) r_imem[w_iidx][8*i +: 8] <= writedata[8*i +: 8];
        else        r_dmem[w_didx][8*i +: 8] <= writedata[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_avalon_bus_ram.sv
// Self-checking bench for avalon_bus_ram: four instances with WAIT_CYCLES 0..3, directed
// vectors, hand sequences for reset/abort corners, and randomized traffic against a model.
module tb_avalon_bus_ram;

  logic        clk = 1'b0;
  logic        rst    [4];
  logic        rd     [4];
  logic        wr     [4];
  logic [31:0] addr   [4];
  logic [3:0]  be     [4];
  logic [31:0] wd     [4];
  logic        wait_w [4];
  logic [31:0] rdata  [4];
  logic        berr   [4];

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    avalon_bus_ram #(.WAIT_CYCLES(g)) u_dut (
      .clk(clk), .reset(rst[g]), .address(addr[g]), .read(rd[g]), .write(wr[g]),
      .byteenable(be[g]), .writedata(wd[g]), .waitrequest(wait_w[g]),
      .readdata(rdata[g]), .bus_error(berr[g])
    );
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h expected %h", name, got, exp);
    end
  endtask

  // One access on instance d: returns completion-cycle readdata and number of stall cycles.
  task automatic access(input int d, input bit r, input bit w, input logic [31:0] a,
                        input logic [3:0] b, input logic [31:0] dat,
                        output logic [31:0] got, output int stalls);
    bit ok;
    @(negedge clk);
    rd[d] = r; wr[d] = w; addr[d] = a; be[d] = b; wd[d] = dat;
    stalls = 0; ok = 1'b0; got = 32'h0;
    #1;
    for (int i = 0; i < 40; i++) begin
      if (!wait_w[d]) begin
        got = rdata[d]; ok = 1'b1;
        break;
      end
      stalls++;
      @(negedge clk); #1;
    end
    check("access_timeout", {31'd0, ok}, 32'd1);
    @(posedge clk); #1;
    rd[d] = 1'b0; wr[d] = 1'b0;
  endtask

  task automatic pulse_reset(input int d);
    @(negedge clk); rst[d] = 1'b1;
    @(posedge clk); #1; rst[d] = 1'b0;
  endtask

  typedef struct {
    bit          rd;
    bit          wr;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    bit          exp_err;
  } vec_t;

  // Reference model: word store keyed by aligned byte address, sticky error bit.
  logic [31:0] m_mem [bit [31:0]];
  bit          m_err;

  function automatic bit mapped(input logic [31:0] a);
    return (a < 32'h0000_1000) || (a >= 32'hBFC0_0000 && a < 32'hBFC0_1000);
  endfunction

  initial begin
    vec_t        vt [$];
    logic [31:0] got, exp_word, a;
    int          st;
    logic [31:0] pool [8];

    for (int d = 0; d < 4; d++) begin
      rst[d] = 1'b1; rd[d] = 1'b0; wr[d] = 1'b0;
      addr[d] = 32'h0; be[d] = 4'h0; wd[d] = 32'h0;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 4; d++) begin
      check("reset_wait", {31'd0, wait_w[d]}, 32'd0);
      check("reset_rdata", rdata[d], 32'h0);
      check("reset_berr", {31'd0, berr[d]}, 32'd0);
    end
    for (int d = 0; d < 4; d++) rst[d] = 1'b0;

    // Directed vectors on the one-wait-state instance.
    vt.push_back('{0, 1, 32'h0000_0190, 4'hF, 32'd123,        32'h0,        0});
    vt.push_back('{1, 0, 32'h0000_0190, 4'hF, 32'h0,          32'd123,      0});
    vt.push_back('{0, 1, 32'h0000_0320, 4'hF, 32'hAABB_CCDD,  32'h0,        0});
    vt.push_back('{0, 1, 32'h0000_0320, 4'h5, 32'h1122_3344,  32'h0,        0});
    vt.push_back('{1, 0, 32'h0000_0320, 4'hF, 32'h0,          32'hAA22_CC44, 0});
    vt.push_back('{0, 1, 32'h0000_0320, 4'h0, 32'hFFFF_FFFF,  32'h0,        0});
    vt.push_back('{1, 0, 32'h0000_0320, 4'hF, 32'h0,          32'hAA22_CC44, 0});
    vt.push_back('{0, 1, 32'h0000_0FFC, 4'hF, 32'hDEAD_BEEF,  32'h0,        0});
    vt.push_back('{1, 0, 32'h0000_0FFC, 4'hF, 32'h0,          32'hDEAD_BEEF, 0});
    vt.push_back('{0, 1, 32'hBFC0_0FFC, 4'hF, 32'h1234_5678,  32'h0,        0});
    vt.push_back('{1, 0, 32'hBFC0_0FFC, 4'hF, 32'h0,          32'h1234_5678, 0});
    vt.push_back('{1, 0, 32'h1000_0000, 4'hF, 32'h0,          32'h0,        1});
    vt.push_back('{1, 0, 32'h0000_0190, 4'hF, 32'h0,          32'd123,      1});
    vt.push_back('{0, 1, 32'h0000_0322, 4'hF, 32'h5555_5555,  32'h0,        1});
    vt.push_back('{1, 0, 32'h0000_0320, 4'hF, 32'h0,          32'hAA22_CC44, 1});
    vt.push_back('{1, 1, 32'h0000_0320, 4'hF, 32'h0000_0000,  32'h0,        1});
    vt.push_back('{1, 0, 32'h0000_0320, 4'hF, 32'h0,          32'hAA22_CC44, 1});
    vt.push_back('{1, 0, 32'h0000_1000, 4'hF, 32'h0,          32'h0,        1});
    vt.push_back('{1, 0, 32'hBFBF_FFFC, 4'hF, 32'h0,          32'h0,        1});
    for (int i = 0; i < vt.size(); i++) begin
      access(1, vt[i].rd, vt[i].wr, vt[i].addr, vt[i].be, vt[i].wd, got, st);
      check("vec_stalls", st, 32'd1);
      if (vt[i].rd) begin
        check("vec_rdata", got, vt[i].exp_rd);
        check("vec_rdata_held", rdata[1], vt[i].exp_rd);
      end
      check("vec_berr", {31'd0, berr[1]}, {31'd0, vt[i].exp_err});
    end

    // Three wait states, back-to-back fetches.
    access(3, 0, 1, 32'hBFC0_0004, 4'hF, 32'h8C01_0064, got, st);
    access(3, 1, 0, 32'hBFC0_0004, 4'hF, 32'h0, got, st);
    check("w3_stalls", st, 32'd3);
    check("w3_rdata", got, 32'h8C01_0064);
    access(3, 1, 0, 32'hBFC0_0004, 4'hF, 32'h0, got, st);
    check("w3_b2b_stalls", st, 32'd3);
    check("w3_b2b_rdata", got, 32'h8C01_0064);

    // Zero wait states.
    access(0, 0, 1, 32'h0000_0040, 4'hF, 32'hA5A5_5A5A, got, st);
    check("w0_wr_stalls", st, 32'd0);
    access(0, 0, 1, 32'h0000_0040, 4'h8, 32'h11FF_FFFF, got, st);
    access(0, 1, 0, 32'h0000_0040, 4'hF, 32'h0, got, st);
    check("w0_rd_stalls", st, 32'd0);
    check("w0_rdata", got, 32'h11A5_5A5A);

    // Two wait states: withdrawn request, reset mid-access, individual error kinds.
    access(2, 0, 1, 32'h0000_0324, 4'hF, 32'h0000_1111, got, st);
    access(2, 1, 0, 32'h0000_0324, 4'hF, 32'h0, got, st);
    check("w2_rdata", got, 32'h0000_1111);
    @(negedge clk); wr[2] = 1'b1; addr[2] = 32'h0000_0324; wd[2] = 32'hFFFF_FFFF; be[2] = 4'hF;
    @(negedge clk); wr[2] = 1'b0;
    @(posedge clk); #1;
    check("drop_berr", {31'd0, berr[2]}, 32'd1);
    @(negedge clk); wr[2] = 1'b1; addr[2] = 32'h0000_0324; wd[2] = 32'hFFFF_FFFF;
    @(negedge clk); #1;
    check("mid_wait", {31'd0, wait_w[2]}, 32'd1);
    rst[2] = 1'b1;
    @(posedge clk); #1;
    check("mid_berr", {31'd0, berr[2]}, 32'd0);
    rst[2] = 1'b0; wr[2] = 1'b0;
    #1;
    check("mid_rdata", rdata[2], 32'h0);
    check("mid_wait_idle", {31'd0, wait_w[2]}, 32'd0);
    access(2, 1, 0, 32'h0000_0324, 4'hF, 32'h0, got, st);
    check("post_rst_stalls", st, 32'd2);
    check("post_rst_rdata", got, 32'h0000_1111);
    check("post_rst_berr", {31'd0, berr[2]}, 32'd0);
    access(2, 1, 0, 32'h0000_0326, 4'hF, 32'h0, got, st);
    check("unal_rdata", got, 32'h0);
    check("unal_berr", {31'd0, berr[2]}, 32'd1);
    pulse_reset(2);
    check("clr_berr", {31'd0, berr[2]}, 32'd0);
    access(2, 1, 1, 32'h0000_0324, 4'hF, 32'h0, got, st);
    check("rw_rdata", got, 32'h0);
    check("rw_berr", {31'd0, berr[2]}, 32'd1);
    pulse_reset(2);
    access(2, 0, 1, 32'hBFC0_1000, 4'hF, 32'h0, got, st);
    check("unmap_wr_berr", {31'd0, berr[2]}, 32'd1);
    access(2, 1, 0, 32'h0000_0324, 4'hF, 32'h0, got, st);
    check("final_w2_rdata", got, 32'h0000_1111);

    // Randomized traffic on the one-wait-state instance against the model.
    pulse_reset(1);
    m_err = 1'b0;
    for (int i = 0; i < 8; i++) begin
      pool[i] = (i < 4) ? (32'h0000_0000 + 32'($urandom_range(0, 1023)) * 32'd4)
                        : (32'hBFC0_0000 + 32'($urandom_range(0, 1023)) * 32'd4);
      exp_word = $urandom;
      access(1, 0, 1, pool[i], 4'hF, exp_word, got, st);
      m_mem[pool[i]] = exp_word;
    end
    for (int n = 0; n < 120; n++) begin
      int          op;
      bit          r, w;
      logic [3:0]  b;
      logic [31:0] dat;
      op = $urandom_range(0, 9);
      a = pool[$urandom_range(0, 7)];
      b = 4'($urandom_range(0, 15));
      dat = $urandom;
      r = (op <= 3) || (op == 9) || (op == 7 && dat[0]);
      w = (op >= 4 && op <= 6) || op == 8 || op == 9 || (op == 7 && !dat[0]);
      if (op == 7) a = 32'h2000_0000 | (32'($urandom) & 32'h0FFF_FFFC);
      if (op == 8) a = a | 32'($urandom_range(1, 3));
      access(1, r, w, a, b, dat, got, st);
      if (!mapped(a) || a[1:0] != 2'b00 || (r && w)) begin
        m_err = 1'b1;
        exp_word = 32'h0;
      end else begin
        if (w) begin
          for (int k = 0; k < 4; k++)
            if (b[k]) m_mem[a][8*k +: 8] = dat[8*k +: 8];
        end
        exp_word = m_mem[a];
      end
      check("rnd_stalls", st, 32'd1);
      if (r) check("rnd_rdata", got, exp_word);
      check("rnd_berr", {31'd0, berr[1]}, {31'd0, m_err});
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
